// File: rtl/exe_div_stage.sv
// Iterative restoring radix-2 divider for the EXE stage: div/mod, signed/unsigned,
// one quotient bit per cycle, valid/allowin handshake on both sides, dest tag carried.
module exe_div_stage #(
   parameter int WIDTH = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_allowin,
   input  logic [1:0]       in_op,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_allowin,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             div_by_zero,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state, state_nxt;
   logic [1:0]       op_q;
   logic [TAG_W-1:0] tag_q;
   logic [WIDTH-1:0] dvs_q, quo_q, rem_q, res_q;
   logic [CW-1:0]    count_q;
   logic             q_neg_q, r_neg_q, dbz_q;

   logic             accept, src_signed, s1_neg, s2_neg, src2_zero, last, ge;
   logic [WIDTH-1:0] abs1, abs2, quo_nxt, rem_nxt, q_fix, r_fix;
   logic [WIDTH:0]   trial;

   assign in_allowin = ~flush & ((state == IDLE) | ((state == DONE) & out_allowin));
   assign accept     = in_valid & in_allowin;
   assign src_signed = ~in_op[1];
   assign s1_neg     = src_signed & in_src1[WIDTH-1];
   assign s2_neg     = src_signed & in_src2[WIDTH-1];
   assign abs1       = s1_neg ? -in_src1 : in_src1;
   assign abs2       = s2_neg ? -in_src2 : in_src2;
   assign src2_zero  = (in_src2 == '0);
   assign last       = (count_q == CW'(WIDTH - 1));

   // Remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow.
   assign trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
   assign ge      = ~trial[WIDTH];
   assign rem_nxt = ge ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
   assign quo_nxt = {quo_q[WIDTH-2:0], ge};
   assign q_fix   = q_neg_q ? -quo_nxt : quo_nxt;
   assign r_fix   = r_neg_q ? -rem_nxt : rem_nxt;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = src2_zero ? DONE : CALC;
         CALC: if (last) state_nxt = DONE;
         DONE: begin
            if (accept)           state_nxt = src2_zero ? DONE : CALC;
            else if (out_allowin) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (flush) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= '0;
         tag_q   <= '0;
         dvs_q   <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         res_q   <= '0;
         count_q <= '0;
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
         dbz_q   <= 1'b0;
      end else if (accept) begin
         op_q    <= in_op;
         tag_q   <= in_tag;
         dvs_q   <= abs2;
         quo_q   <= abs1;
         rem_q   <= '0;
         count_q <= '0;
         q_neg_q <= s1_neg ^ s2_neg;
         r_neg_q <= s1_neg;
         dbz_q   <= src2_zero;
         // Zero divisor skips CALC, so the result is fixed right here.
         if (src2_zero) res_q <= in_op[0] ? in_src1 : '1;
      end else if (state == CALC && !flush) begin
         quo_q   <= quo_nxt;
         rem_q   <= rem_nxt;
         count_q <= count_q + CW'(1);
         if (last) res_q <= op_q[0] ? r_fix : q_fix;
      end
   end

   assign out_valid   = (state == DONE);
   assign out_result  = res_q;
   assign out_tag     = tag_q;
   assign div_by_zero = dbz_q;
   assign busy        = (state != IDLE);

endmodule

// File: tb/tb_exe_div_stage.sv
// Directed-vector bench for exe_div_stage: table of ops plus backpressure,
// flush and mid-operation reset sequences.
module tb_exe_div_stage;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, in_allowin, out_valid, out_allowin;
   logic        div_by_zero, busy;
   logic [1:0]  in_op;
   logic [31:0] in_src1, in_src2, out_result;
   logic [4:0]  in_tag, out_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   exe_div_stage #(.WIDTH(32), .TAG_W(5)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_allowin(in_allowin), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
      .out_valid(out_valid), .out_allowin(out_allowin), .out_result(out_result),
      .out_tag(out_tag), .div_by_zero(div_by_zero), .busy(busy)
   );

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  tag;
      logic [31:0] exp;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Drives one request at a negedge; returns just after the accepting edge.
   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
      @(negedge clk);
      in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = tag;
      @(posedge clk);
   endtask

   // Counts cycles after the accept edge until out_valid, sampled on negedges.
   task automatic wait_result(output int lat);
      lat = 1;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int  lat;
      bit  seen;

      vecs[0]  = '{2'b00, 32'd100,       32'd7,         5'd1,  32'd14,        1'b0, 33};
      vecs[1]  = '{2'b01, 32'hFFFFFF9C,  32'd7,         5'd2,  32'hFFFFFFFE,  1'b0, 33};
      vecs[2]  = '{2'b00, 32'hFFFFFF9C,  32'd7,         5'd3,  32'hFFFFFFF2,  1'b0, 33};
      vecs[3]  = '{2'b10, 32'hFFFFFFFF,  32'd2,         5'd4,  32'h7FFFFFFF,  1'b0, 33};
      vecs[4]  = '{2'b11, 32'h80000000,  32'd3,         5'd5,  32'd2,         1'b0, 33};
      vecs[5]  = '{2'b00, 32'd5,         32'd0,         5'd6,  32'hFFFFFFFF,  1'b1, 1};
      vecs[6]  = '{2'b01, 32'd5,         32'd0,         5'd7,  32'd5,         1'b1, 1};
      vecs[7]  = '{2'b00, 32'h80000000,  32'hFFFFFFFF,  5'd8,  32'h80000000,  1'b0, 33};
      vecs[8]  = '{2'b01, 32'h80000000,  32'hFFFFFFFF,  5'd9,  32'd0,         1'b0, 33};
      vecs[9]  = '{2'b01, 32'd7,         32'hFFFFFFFD,  5'd10, 32'd1,         1'b0, 33};
      vecs[10] = '{2'b00, 32'hFFFFFFF9,  32'hFFFFFFFE,  5'd11, 32'd3,         1'b0, 33};
      vecs[11] = '{2'b01, 32'hFFFFFFF9,  32'hFFFFFFFE,  5'd12, 32'hFFFFFFFF,  1'b0, 33};
      vecs[12] = '{2'b10, 32'd7,         32'hFFFFFFFF,  5'd13, 32'd0,         1'b0, 33};
      vecs[13] = '{2'b11, 32'hFFFFFFFB,  32'd0,         5'd14, 32'hFFFFFFFB,  1'b1, 1};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b1;
      in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
      repeat (3) @(negedge clk);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst out_result", out_result, 32'd0);
      chk("rst out_tag", {27'd0, out_tag}, 32'd0);
      chk("rst div_by_zero", {31'd0, div_by_zero}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
      reset = 1'b0;
      #1;
      chk("idle in_allowin", {31'd0, in_allowin}, 32'd1);

      for (int i = 0; i < 14; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
         wait_result(lat);
         chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d result", i), out_result, vecs[i].exp);
         chk($sformatf("vec%0d tag", i), {27'd0, out_tag}, {27'd0, vecs[i].tag});
         chk($sformatf("vec%0d dbz", i), {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
         @(negedge clk);
         chk($sformatf("vec%0d drained", i), {31'd0, busy}, 32'd0);
      end

      // Backpressure for 10 cycles, then a back-to-back accept on release.
      out_allowin = 1'b0;
      issue(2'b00, 32'd100, 32'd7, 5'd3);
      wait_result(lat);
      chk("bp latency", lat, 33);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (!out_valid || out_result !== 32'd14 || out_tag !== 5'd3 || in_allowin)
            seen = 1'b1;
      end
      chk("bp held stable", {31'd0, seen}, 32'd0);
      out_allowin = 1'b1;
      in_valid = 1'b1; in_op = 2'b10; in_src1 = 32'hFFFFFFFF; in_src2 = 32'd2; in_tag = 5'd9;
      #1;
      chk("b2b in_allowin", {31'd0, in_allowin}, 32'd1);
      @(posedge clk);
      wait_result(lat);
      chk("b2b latency", lat, 33);
      chk("b2b result", out_result, 32'h7FFFFFFF);
      chk("b2b tag", {27'd0, out_tag}, 32'd9);

      // Flush in CALC at count 10, with a competing request in the same cycle.
      issue(2'b00, 32'd1000, 32'd3, 5'd17);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; in_src2 = 32'd3;
      #1;
      chk("flush in_allowin", {31'd0, in_allowin}, 32'd0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      chk("flush busy", {31'd0, busy}, 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (out_valid || busy) seen = 1'b1;
         @(negedge clk);
      end
      chk("flush no result", {31'd0, seen}, 32'd0);

      // Reset mid-CALC, then a normal op.
      issue(2'b00, 32'd100, 32'd7, 5'd21);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst busy", {31'd0, busy}, 32'd0);
      chk("midrst out_valid", {31'd0, out_valid}, 32'd0);
      chk("midrst out_result", out_result, 32'd0);
      chk("midrst out_tag", {27'd0, out_tag}, 32'd0);
      reset = 1'b0;
      issue(2'b01, 32'd100, 32'd7, 5'd22);
      wait_result(lat);
      chk("postrst latency", lat, 33);
      chk("postrst result", out_result, 32'd2);
      chk("postrst tag", {27'd0, out_tag}, 32'd22);
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
